// File: rtl/qu_int_rs.sv
// -----------------------------------------------------------------------------
// qu_uop: shared micro-op definitions produced by decode/rename.
//   PHY_RF_ADDR_WIDTH : physical register tag width
//   optype_e          : functional class of a uop
//   uop_ic_t          : packed view of a uop as seen by integer/control units
//   UOP_WIDTH         : width of the packed uop bus
//
// qu_int_rs: integer/control reservation station.
//   Buffers INT / BRANCH / CONT uops in a compacting, age-ordered array
//   (entry 0 is the oldest), tracks source readiness through a result-tag
//   wakeup bus and grants the oldest fully-ready uop to the execute stage.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   uop_i           dispatched uop (uop_ic_t layout)
//   uop_valid_i     dispatch valid
//   uop_ready_o     dispatch ready: a free entry exists
//   rs1/rs2_ready_i busy-table status of the dispatched sources
//   wakeup_valid_i  per-port broadcast valid
//   wakeup_tag_i    per-port physical destination tag (port p in slice p)
//   flush_i         discard all entries at the next edge
//   issue_uop_o     selected uop bits (zero when nothing is selectable)
//   issue_valid_o   selected uop may execute this cycle
//   issue_ready_i   execute stage accepts this cycle
//   occupancy_o     registered count of valid entries
//
// Handshakes: dispatch transfers on uop_valid_i && uop_ready_o at the
// rising edge. Issue is a per-cycle grant: a uop leaves on
// issue_valid_o && issue_ready_i, and while issue_ready_i is low the
// offered uop may change (e.g. an older entry becomes ready).
// -----------------------------------------------------------------------------
package qu_uop;
  localparam int PHY_RF_ADDR_WIDTH = 6;

  typedef enum logic [2:0] {
    OPTYPE_INT    = 3'd0,
    OPTYPE_BRANCH = 3'd1,
    OPTYPE_CONT   = 3'd2,
    OPTYPE_LOAD   = 3'd3,
    OPTYPE_STORE  = 3'd4,
    OPTYPE_FP     = 3'd5,
    OPTYPE_CSR    = 3'd6,
    OPTYPE_NOP    = 3'd7
  } optype_e;

  typedef struct packed {
    optype_e                      optype;
    logic [3:0]                   func;
    logic                         rs1_valid;
    logic [PHY_RF_ADDR_WIDTH-1:0] rs1;
    logic                         rs2_valid;
    logic [PHY_RF_ADDR_WIDTH-1:0] rs2;
    logic                         rd_valid;
    logic [PHY_RF_ADDR_WIDTH-1:0] rd;
    logic [31:0]                  imm;
    logic [7:0]                   rob_idx;
  } uop_ic_t;

  localparam int UOP_WIDTH = $bits(uop_ic_t);
endpackage

module qu_int_rs
  import qu_uop::*;
#(
  parameter int RS_DEPTH     = 8,
  parameter int WAKEUP_PORTS = 2
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic [UOP_WIDTH-1:0]                      uop_i,
  input  logic                                      uop_valid_i,
  output logic                                      uop_ready_o,
  input  logic                                      rs1_ready_i,
  input  logic                                      rs2_ready_i,
  input  logic [WAKEUP_PORTS-1:0]                   wakeup_valid_i,
  input  logic [WAKEUP_PORTS*PHY_RF_ADDR_WIDTH-1:0] wakeup_tag_i,
  input  logic                                      flush_i,
  output logic [UOP_WIDTH-1:0]                      issue_uop_o,
  output logic                                      issue_valid_o,
  input  logic                                      issue_ready_i,
  output logic [$clog2(RS_DEPTH):0]                 occupancy_o
);

  localparam int IDX_W = $clog2(RS_DEPTH);
  localparam int CNT_W = IDX_W + 1;
  localparam int TAG_W = PHY_RF_ADDR_WIDTH;

  // Entry storage. Valid entries always occupy indices 0..count-1.
  logic [UOP_WIDTH-1:0] e_uop [RS_DEPTH];
  logic [RS_DEPTH-1:0]  e_valid;
  logic [RS_DEPTH-1:0]  e_r1;
  logic [RS_DEPTH-1:0]  e_r2;
  logic [CNT_W-1:0]     count;

  // Next-state images of the array.
  logic [UOP_WIDTH-1:0] n_uop [RS_DEPTH];
  logic [RS_DEPTH-1:0]  n_valid;
  logic [RS_DEPTH-1:0]  n_r1;
  logic [RS_DEPTH-1:0]  n_r2;
  logic [CNT_W-1:0]     count_after;
  logic [CNT_W-1:0]     count_next;

  // Readiness including this cycle's wakeup broadcast.
  logic [RS_DEPTH-1:0]  w_r1;
  logic [RS_DEPTH-1:0]  w_r2;

  logic                 sel_found;
  logic [IDX_W-1:0]     sel_idx;
  logic                 issue_fire;
  logic                 disp_fire;
  logic                 disp_keep;
  logic                 in_r1;
  logic                 in_r2;
  logic [IDX_W-1:0]     wr_idx;
  uop_ic_t              in_view;

  // True when any valid wakeup port carries exactly this tag.
  function automatic logic tag_hit(
    input logic [TAG_W-1:0]              tag,
    input logic [WAKEUP_PORTS-1:0]       wv,
    input logic [WAKEUP_PORTS*TAG_W-1:0] wt
  );
    logic hit;
    hit = 1'b0;
    for (int p = 0; p < WAKEUP_PORTS; p++) begin
      if (wv[p] && (wt[p*TAG_W +: TAG_W] == tag)) hit = 1'b1;
    end
    return hit;
  endfunction

  assign in_view = uop_ic_t'(uop_i);

  // Wakeup: readiness bits only ever go from 0 to 1 while an entry lives.
  always_comb begin
    uop_ic_t ev;
    ev   = '0;
    w_r1 = e_r1;
    w_r2 = e_r2;
    for (int i = 0; i < RS_DEPTH; i++) begin
      ev = uop_ic_t'(e_uop[i]);
      if (e_valid[i] && ev.rs1_valid && tag_hit(ev.rs1, wakeup_valid_i, wakeup_tag_i))
        w_r1[i] = 1'b1;
      if (e_valid[i] && ev.rs2_valid && tag_hit(ev.rs2, wakeup_valid_i, wakeup_tag_i))
        w_r2[i] = 1'b1;
    end
  end

  // Select: scanning from the top down leaves the lowest (oldest) ready index.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = RS_DEPTH - 1; i >= 0; i--) begin
      if (e_valid[i] && e_r1[i] && e_r2[i]) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
      end
    end
  end

  assign issue_valid_o = sel_found && !flush_i && !rst;
  assign issue_uop_o   = (sel_found && !rst) ? e_uop[sel_idx] : '0;
  assign issue_fire    = issue_valid_o && issue_ready_i;

  // Ready does not look at a same-cycle issue: a full station stalls
  // dispatch for one cycle even if an entry is leaving.
  assign uop_ready_o = !rst && (count < CNT_W'(RS_DEPTH));
  assign occupancy_o = count;

  // Non-integer uops are accepted (so dispatch never stalls on them) and dropped.
  assign disp_fire = uop_valid_i && uop_ready_o && !flush_i;
  assign disp_keep = disp_fire &&
                     (in_view.optype inside {OPTYPE_INT, OPTYPE_BRANCH, OPTYPE_CONT});

  // A source is ready if unused, already produced, or produced this cycle.
  assign in_r1 = !in_view.rs1_valid || rs1_ready_i ||
                 tag_hit(in_view.rs1, wakeup_valid_i, wakeup_tag_i);
  assign in_r2 = !in_view.rs2_valid || rs2_ready_i ||
                 tag_hit(in_view.rs2, wakeup_valid_i, wakeup_tag_i);

  // The new uop lands just after the last surviving entry; when disp_keep is
  // set count_after is below RS_DEPTH, so the index fits in IDX_W bits.
  assign count_after = count - CNT_W'(issue_fire);
  assign wr_idx      = count_after[IDX_W-1:0];
  assign count_next  = count_after + CNT_W'(disp_keep);

  // Removal and compaction first, then the dispatch write on top.
  always_comb begin
    for (int i = 0; i < RS_DEPTH; i++) begin
      n_uop[i] = e_uop[i];
    end
    n_valid = e_valid;
    n_r1    = w_r1;
    n_r2    = w_r2;

    if (issue_fire) begin
      for (int i = 0; i < RS_DEPTH - 1; i++) begin
        if (IDX_W'(i) >= sel_idx) begin
          n_uop[i]   = e_uop[i+1];
          n_valid[i] = e_valid[i+1];
          n_r1[i]    = w_r1[i+1];
          n_r2[i]    = w_r2[i+1];
        end
      end
      n_valid[RS_DEPTH-1] = 1'b0;
      n_r1[RS_DEPTH-1]    = 1'b0;
      n_r2[RS_DEPTH-1]    = 1'b0;
    end

    if (disp_keep) begin
      n_uop[wr_idx]   = uop_i;
      n_valid[wr_idx] = 1'b1;
      n_r1[wr_idx]    = in_r1;
      n_r2[wr_idx]    = in_r2;
    end
  end

  // Control state: reset and flush share one path.
  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      e_valid <= '0;
      e_r1    <= '0;
      e_r2    <= '0;
      count   <= '0;
    end else begin
      e_valid <= n_valid;
      e_r1    <= n_r1;
      e_r2    <= n_r2;
      count   <= count_next;
    end
  end

  // Payload needs no reset: it is only observed through valid entries.
  always_ff @(posedge clk) begin
    for (int i = 0; i < RS_DEPTH; i++) begin
      e_uop[i] <= n_uop[i];
    end
  end

endmodule

// File: doc/qu_int_rs.md
Name: qu_int_rs

Overview:
Integer/control reservation station. It is the consumer of the packed uop_t stream produced by decode/rename. It buffers INT, BRANCH and CONT micro-ops and tracks source-operand readiness through a result-tag wakeup bus. Each cycle it issues the oldest fully-ready uop to the luftALU execute stage.

Parameters:
RS_DEPTH, 8, number of entries (power of two, >=2)
WAKEUP_PORTS, 2, number of result-tag broadcast ports per cycle

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
uop_i  in  qu_uop::UOP_WIDTH  dispatched uop, interpreted through the uop_ic view
uop_valid_i  in  1  dispatch valid
uop_ready_o  out  1  dispatch ready (a free entry exists)
rs1_ready_i  in  1  busy-table status of uop_i.rs1 at dispatch
rs2_ready_i  in  1  busy-table status of uop_i.rs2 at dispatch
wakeup_valid_i  in  WAKEUP_PORTS  per-port broadcast valid
wakeup_tag_i  in  WAKEUP_PORTS*PHY_RF_ADDR_WIDTH  per-port physical destination tag
flush_i  in  1  discard all entries
issue_uop_o  out  qu_uop::UOP_WIDTH  selected uop, unmodified bits
issue_valid_o  out  1  issue_uop_o is ready to execute
issue_ready_i  in  1  execute stage accepts this cycle
occupancy_o  out  $clog2(RS_DEPTH)+1  valid entry count

Behaviour:
- Storage:
  - Compacting, age-ordered array. Entry 0 is the oldest.
  - Each entry holds: uop, valid bit, r1 bit, r2 bit.
  - occupancy_o is a registered count.
- Dispatch:
  - Transfer occurs on uop_valid_i && uop_ready_o.
  - uop_ready_o = !rst && (count < RS_DEPTH). It does not depend on an issue in the same cycle (no full-queue pass-through).
  - Uops with optype not in {OPTYPE_INT, OPTYPE_BRANCH, OPTYPE_CONT} are consumed and dropped; count is unchanged.
- Readiness at write:
  - r1 = !rs1_valid || rs1_ready_i || (a matching tag on any valid wakeup port in the same cycle).
  - r2 is computed the same way from rs2.
- Wakeup:
  - On each edge, every valid entry whose rsN_valid is set and whose rsN equals any valid wakeup tag sets rN.
  - Multiple ports hitting the same entry is harmless.
  - Readiness bits are registered. An entry woken in cycle N is first selectable in cycle N+1.
- Select:
  - Combinational priority pick of the lowest-index entry with valid && r1 && r2.
  - issue_valid_o = such an entry exists && !flush_i && !rst.
  - issue_uop_o = that entry's uop, or zero when there is none.
  - This is a per-cycle grant, not a stable valid/ready channel. The selected uop may change between cycles while issue_ready_i is low, for example when an older entry becomes ready.
- Issue:
  - On issue_valid_o && issue_ready_i, the selected entry is removed at the edge.
  - Entries above it shift down by one; relative order is preserved.
- Simultaneous dispatch and issue:
  - Removal and shift are applied first, then the new uop is written at index (count-1). Count is unchanged.
  - A shifted entry that is also woken keeps the wakeup.
- Latency:
  - A uop accepted at edge E with both operands ready can issue in the cycle following E (1 cycle).
  - A uop waiting on wakeup issues 1 cycle after the wakeup edge.
- Flush:
  - flush_i clears all valid bits and the count at the next edge.
  - A dispatch or issue handshake in the flush cycle has no effect. issue_valid_o is forced low, so no handshake occurs.
- Reset:
  - rst clears all valid bits and the count.
  - Outputs during and after reset: issue_valid_o=0, issue_uop_o=0, occupancy_o=0, uop_ready_o=0 while rst is high, 1 from the first cycle after.
  - Reset applied mid-operation behaves identically to flush.
- Widths: tag compares are full PHY_RF_ADDR_WIDTH equality; the count never exceeds RS_DEPTH.

Test Plan:
1. Dispatch INT uop (rs1=5, rs2=6, both ready_i=1), issue_ready_i=1 -> issue_valid_o=1 next cycle with identical bits; occupancy 1 -> 0.
2. Dispatch A (rs1=9, not ready), then B (ready); hold issue_ready_i=1 -> B issues first. Wakeup tag 9 at cycle N -> A issues in N+1.
3. Fill 8 entries, none ready -> uop_ready_o=0, occupancy_o=8. Wake all, issue_ready_i=1 -> issue in dispatch order, one per cycle; uop_ready_o=1 after the first issue.
4. At occupancy 7, dispatch and issue in the same cycle -> occupancy stays 7; the new uop is youngest and order is preserved.
5. Dispatch with rs1 tag=3 while wakeup_tag_i port1=3 is valid in the same cycle -> entry marked ready, issues next cycle. Dispatch OPTYPE_LOAD -> dropped, occupancy unchanged.
6. With 5 entries, assert flush_i together with a dispatch -> occupancy 0, issue_valid_o=0 that cycle and the next. Repeat with rst -> same result, and uop_ready_o=0 during rst.
